// File: rtl/sqed_dup_scheduler_if.sv
// rtl/sqed_dup_scheduler_if.sv - control/status bundle between instruction source, QED transformer and scheduler
interface sqed_dup_scheduler_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] orig_limit;
    logic             stall_IF;
    logic             arfwe1;
    logic             arfwe2;
    logic             ena;
    logic             exec_dup;
    logic             busy;
    logic             qed_ready;
    logic             timeout;
    logic [CNT_W-1:0] orig_cnt;
    logic [CNT_W:0]   commit_cnt;

    modport master (
        output start, orig_limit, stall_IF, arfwe1, arfwe2,
        input  ena, exec_dup, busy, qed_ready, timeout, orig_cnt, commit_cnt
    );

    modport slave (
        input  start, orig_limit, stall_IF, arfwe1, arfwe2,
        output ena, exec_dup, busy, qed_ready, timeout, orig_cnt, commit_cnt
    );
endinterface

// File: rtl/sqed_dup_scheduler.sv
// rtl/sqed_dup_scheduler.sv - sequences original burst, duplicate burst and commit drain for SQED runs
module sqed_dup_scheduler #(
    parameter int CNT_W         = 8,
    parameter int MAX_ORIG      = 16,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int TO_W          = 8
) (
    input logic                 din_clk,
    input logic                 din_rst_n,
    sqed_dup_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ORIG,
        S_DUP,
        S_DRAIN,
        S_CHECK_OK,
        S_CHECK_TO
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] orig_cnt;
    logic [CNT_W-1:0] dup_cnt;
    logic [CNT_W:0]   commit_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             issuing;
    logic             accept;
    logic             counting;
    logic             run_start;
    logic [CNT_W+1:0] commit_sum;
    logic [CNT_W:0]   commit_sat;
    logic [CNT_W:0]   commit_next;
    logic [CNT_W:0]   orig_x2;
    logic [CNT_W-1:0] lim_clamped;

    // Issue acceptance is gated only by the registered state, so ena never depends on stall_IF.
    assign issuing   = (state == S_ORIG) || (state == S_DUP);
    assign accept    = issuing && !bus.stall_IF;
    assign counting  = issuing || (state == S_DRAIN);
    assign run_start = (state == S_IDLE) && bus.start;

    // One extra bit of headroom lets a double commit be detected and clamped at all-ones.
    assign commit_sum  = {1'b0, commit_cnt} + (CNT_W+2)'(bus.arfwe1) + (CNT_W+2)'(bus.arfwe2);
    assign commit_sat  = commit_sum[CNT_W+1] ? '1 : commit_sum[CNT_W:0];
    assign commit_next = counting ? commit_sat : commit_cnt;
    assign orig_x2     = {orig_cnt, 1'b0};

    // A zero request still runs one original; requests past the clamp are cut down.
    assign lim_clamped = (bus.orig_limit == '0)                ? CNT_W'(1) :
                         (bus.orig_limit > CNT_W'(MAX_ORIG))   ? CNT_W'(MAX_ORIG) :
                                                                 bus.orig_limit;

    assign bus.orig_cnt   = orig_cnt;
    assign bus.commit_cnt = commit_cnt;

    // State register.
    always_ff @(posedge din_clk or negedge din_rst_n) begin
        if (!din_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_nxt     = state;
        bus.ena       = 1'b0;
        bus.exec_dup  = 1'b0;
        bus.busy      = (state != S_IDLE);
        bus.qed_ready = 1'b0;
        bus.timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ORIG;
                end
            end
            S_ORIG: begin
                bus.ena = 1'b1;
                if (accept && (orig_cnt + CNT_W'(1) == lim)) begin
                    state_nxt = S_DUP;
                end
            end
            S_DUP: begin
                bus.ena      = 1'b1;
                bus.exec_dup = 1'b1;
                if (accept && (dup_cnt + CNT_W'(1) == orig_cnt)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Balanced commits win over a timeout landing in the same cycle.
                if (commit_next >= orig_x2) begin
                    state_nxt = S_CHECK_OK;
                end else if (to_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
                    state_nxt = S_CHECK_TO;
                end
            end
            S_CHECK_OK: begin
                bus.qed_ready = 1'b1;
                state_nxt     = S_IDLE;
            end
            S_CHECK_TO: begin
                bus.timeout = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Run counters: cleared on start, advanced during the run, held afterwards for inspection.
    always_ff @(posedge din_clk or negedge din_rst_n) begin
        if (!din_rst_n) begin
            lim        <= '0;
            orig_cnt   <= '0;
            dup_cnt    <= '0;
            commit_cnt <= '0;
            to_cnt     <= '0;
        end else if (run_start) begin
            lim        <= lim_clamped;
            orig_cnt   <= '0;
            dup_cnt    <= '0;
            commit_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            commit_cnt <= commit_next;
            if (accept && (state == S_ORIG)) begin
                orig_cnt <= orig_cnt + CNT_W'(1);
            end
            if (accept && (state == S_DUP)) begin
                dup_cnt <= dup_cnt + CNT_W'(1);
            end
            if (state == S_DRAIN) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sqed_dup_scheduler.sv
// tb/tb_sqed_dup_scheduler.sv - self-checking bench for sqed_dup_scheduler
module tb_sqed_dup_scheduler;
    localparam int CNT_W = 8;
    localparam int MAXT  = 1024;

    logic din_clk = 1'b0;
    logic din_rst_n;

    sqed_dup_scheduler_if #(.CNT_W(CNT_W)) bus ();

    sqed_dup_scheduler #(
        .CNT_W(CNT_W), .MAX_ORIG(16), .DRAIN_TIMEOUT(64), .TO_W(8)
    ) dut (
        .din_clk(din_clk),
        .din_rst_n(din_rst_n),
        .bus(bus)
    );

    always #5 din_clk = ~din_clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         s_tab  [MAXT];
    logic [1:0] c_tab  [MAXT];
    bit         sp_tab [MAXT];

    int last_n_orig, last_n_dup, last_t_end;
    bit last_ok;

    task automatic step;
        @(posedge din_clk);
        #1;
    endtask

    task automatic clear_tabs;
        for (int i = 0; i < MAXT; i++) begin
            s_tab[i]  = 1'b0;
            c_tab[i]  = 2'b00;
            sp_tab[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs;
        bus.start = 1'b0; bus.orig_limit = '0; bus.stall_IF = 1'b0;
        bus.arfwe1 = 1'b0; bus.arfwe2 = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        din_rst_n = 1'b0;
        step(); step();
        din_rst_n = 1'b1;
        step();
    endtask

    // Cycle 0 is the first ORIG cycle; s_tab/c_tab/sp_tab give per-cycle stall, commits and start pulses.
    task automatic run_case(input string name, input int limit_in, input bit start_on_pulse);
        int lim, zeros, t_orig, t_issue, cum, t_end, exp_cc, t, n_orig, n_dup;
        bit exp_ok, seen, got_ok, got_busy;
        lim = (limit_in == 0) ? 1 : ((limit_in > 16) ? 16 : limit_in);
        zeros = 0; t_orig = 0; t_issue = 0;
        for (int i = 0; i < MAXT && t_issue == 0; i++) begin
            if (!s_tab[i]) begin
                zeros++;
                if (zeros == lim) t_orig = i + 1;
                if (zeros == 2 * lim) t_issue = i + 1;
            end
        end
        cum = 0;
        for (int i = 0; i < t_issue; i++) cum += int'(c_tab[i][0]) + int'(c_tab[i][1]);
        exp_ok = 1'b0;
        t_end = t_issue + 64;
        for (int d = 0; d < 64 && !exp_ok; d++) begin
            cum += int'(c_tab[t_issue + d][0]) + int'(c_tab[t_issue + d][1]);
            if (cum >= 2 * lim) begin
                exp_ok = 1'b1;
                t_end = t_issue + d + 1;
            end
        end
        exp_cc = (cum > 511) ? 511 : cum;

        bus.orig_limit = CNT_W'(limit_in);
        bus.start = 1'b1; bus.stall_IF = 1'b0; bus.arfwe1 = 1'b0; bus.arfwe2 = 1'b0;
        step();
        bus.start = 1'b0;
        n_orig = 0; n_dup = 0; seen = 0; got_ok = 0; got_busy = 0; t = 0;
        while (!seen && t < 400) begin
            bus.stall_IF = s_tab[t];
            bus.arfwe1 = c_tab[t][0];
            bus.arfwe2 = c_tab[t][1];
            bus.start = sp_tab[t];
            if (sp_tab[t]) bus.orig_limit = 8'd7;
            if (bus.qed_ready || bus.timeout) begin
                seen = 1'b1;
                got_ok = bus.qed_ready;
                got_busy = bus.busy;
            end else begin
                if (bus.ena && !bus.exec_dup) n_orig++;
                if (bus.ena && bus.exec_dup) n_dup++;
                step();
                t++;
            end
        end

        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s end_of_run: no qed_ready/timeout within 400 cycles, expected pulse at cycle %0d", name, t_end);
            do_reset();
        end else begin
            n_cmp++;
            if (got_ok !== exp_ok) begin
                n_bad++;
                $display("FAIL %s outcome: qed_ready=%0d expected %0d", name, got_ok, exp_ok);
            end
            n_cmp++;
            if (t !== t_end) begin
                n_bad++;
                $display("FAIL %s pulse_cycle: got %0d expected %0d", name, t, t_end);
            end
            n_cmp++;
            if (n_orig !== t_orig) begin
                n_bad++;
                $display("FAIL %s orig_cycles: got %0d expected %0d", name, n_orig, t_orig);
            end
            n_cmp++;
            if (n_dup !== t_issue - t_orig) begin
                n_bad++;
                $display("FAIL %s dup_cycles: got %0d expected %0d", name, n_dup, t_issue - t_orig);
            end
            n_cmp++;
            if (got_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_in_check: got %0d expected 1", name, got_busy);
            end
            n_cmp++;
            if (bus.orig_cnt !== CNT_W'(lim)) begin
                n_bad++;
                $display("FAIL %s orig_cnt: got %0d expected %0d", name, bus.orig_cnt, lim);
            end
            n_cmp++;
            if (bus.commit_cnt !== (CNT_W+1)'(exp_cc)) begin
                n_bad++;
                $display("FAIL %s commit_cnt: got %0d expected %0d", name, bus.commit_cnt, exp_cc);
            end
            bus.start = start_on_pulse;
            bus.orig_limit = 8'd9;
            step();
            bus.start = 1'b0; bus.stall_IF = 1'b0; bus.arfwe1 = 1'b1; bus.arfwe2 = 1'b1;
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.qed_ready !== 1'b0 || bus.timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL %s after_pulse: busy=%0d qed=%0d to=%0d expected all 0", name, bus.busy, bus.qed_ready, bus.timeout);
            end
            step();
            bus.arfwe1 = 1'b0; bus.arfwe2 = 1'b0;
            n_cmp++;
            if (bus.orig_cnt !== CNT_W'(lim) || bus.commit_cnt !== (CNT_W+1)'(exp_cc)) begin
                n_bad++;
                $display("FAIL %s hold_counts: orig=%0d commit=%0d expected %0d/%0d", name, bus.orig_cnt, bus.commit_cnt, lim, exp_cc);
            end
        end
        last_n_orig = n_orig; last_n_dup = n_dup; last_t_end = t; last_ok = got_ok;
    endtask

    task automatic test_reset;
        idle_inputs();
        din_rst_n = 1'b0;
        step(); step();
        n_cmp++;
        if ({bus.ena, bus.exec_dup, bus.busy, bus.qed_ready, bus.timeout} !== 5'b0 ||
            bus.orig_cnt !== '0 || bus.commit_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ena=%0d dup=%0d busy=%0d qed=%0d to=%0d orig=%0d commit=%0d expected all 0",
                     bus.ena, bus.exec_dup, bus.busy, bus.qed_ready, bus.timeout, bus.orig_cnt, bus.commit_cnt);
        end
        din_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        clear_tabs();
        for (int i = 6; i < 12; i++) c_tab[i] = 2'b01;
        run_case("basic", 3, 1'b0);
        n_cmp++;
        if (last_n_orig !== 3 || last_n_dup !== 3 || last_t_end !== 12 || last_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_shape: orig_cyc=%0d dup_cyc=%0d end=%0d ok=%0d expected 3/3/12/1", last_n_orig, last_n_dup, last_t_end, last_ok);
        end
        n_cmp++;
        if (bus.orig_cnt !== 8'd3 || bus.commit_cnt !== 9'd6) begin
            n_bad++;
            $display("FAIL basic_counts: orig=%0d commit=%0d expected 3/6", bus.orig_cnt, bus.commit_cnt);
        end
    endtask

    task automatic test_stall;
        clear_tabs();
        s_tab[1] = 1'b1;
        s_tab[3] = 1'b1;
        for (int i = 6; i < 10; i++) c_tab[i] = 2'b01;
        run_case("stall", 2, 1'b0);
        n_cmp++;
        if (last_n_orig !== 3 || last_n_dup !== 3 || bus.orig_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL stall_shape: orig_cyc=%0d dup_cyc=%0d orig=%0d expected 3/3/2", last_n_orig, last_n_dup, bus.orig_cnt);
        end
    endtask

    task automatic test_clamp;
        clear_tabs();
        c_tab[2] = 2'b11;
        run_case("clamp_zero", 0, 1'b0);
        n_cmp++;
        if (last_n_orig !== 1 || last_n_dup !== 1 || last_t_end !== 3 || last_ok !== 1'b1 ||
            bus.orig_cnt !== 8'd1 || bus.commit_cnt !== 9'd2) begin
            n_bad++;
            $display("FAIL clamp_zero_shape: orig_cyc=%0d dup_cyc=%0d end=%0d ok=%0d orig=%0d commit=%0d expected 1/1/3/1/1/2",
                     last_n_orig, last_n_dup, last_t_end, last_ok, bus.orig_cnt, bus.commit_cnt);
        end
        clear_tabs();
        for (int i = 32; i < 64; i++) c_tab[i] = 2'b01;
        run_case("clamp_high", 200, 1'b0);
        n_cmp++;
        if (last_n_orig !== 16 || bus.orig_cnt !== 8'd16 || last_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_high_shape: orig_cyc=%0d orig=%0d ok=%0d expected 16/16/1", last_n_orig, bus.orig_cnt, last_ok);
        end
    endtask

    task automatic test_timeout;
        clear_tabs();
        for (int i = 8; i < 13; i++) c_tab[i] = 2'b01;
        run_case("timeout", 4, 1'b0);
        n_cmp++;
        if (last_ok !== 1'b0 || last_t_end !== 72 || bus.commit_cnt !== 9'd5) begin
            n_bad++;
            $display("FAIL timeout_shape: ok=%0d end=%0d commit=%0d expected 0/72/5", last_ok, last_t_end, bus.commit_cnt);
        end
    endtask

    task automatic test_start_busy;
        clear_tabs();
        sp_tab[10] = 1'b1;
        for (int i = 8; i < 16; i++) c_tab[i] = 2'b01;
        run_case("busy_start", 4, 1'b1);
        n_cmp++;
        if (bus.orig_cnt !== 8'd4 || last_t_end !== 16) begin
            n_bad++;
            $display("FAIL busy_start_lim: orig=%0d end=%0d expected 4/16", bus.orig_cnt, last_t_end);
        end
        clear_tabs();
        for (int i = 14; i < 28; i++) c_tab[i] = 2'b01;
        run_case("relatch", 7, 1'b0);
        n_cmp++;
        if (bus.orig_cnt !== 8'd7 || last_n_orig !== 7) begin
            n_bad++;
            $display("FAIL relatch_lim: orig=%0d orig_cyc=%0d expected 7/7", bus.orig_cnt, last_n_orig);
        end
    endtask

    task automatic test_saturate;
        bus.orig_limit = 8'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.stall_IF = 1'b1; bus.arfwe1 = 1'b1; bus.arfwe2 = 1'b1;
        repeat (300) step();
        n_cmp++;
        if (bus.commit_cnt !== 9'd511 || bus.ena !== 1'b1 || bus.exec_dup !== 1'b0 || bus.orig_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL saturate_hold: commit=%0d ena=%0d dup=%0d orig=%0d expected 511/1/0/0",
                     bus.commit_cnt, bus.ena, bus.exec_dup, bus.orig_cnt);
        end
        bus.stall_IF = 1'b0; bus.arfwe1 = 1'b0; bus.arfwe2 = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (bus.qed_ready !== 1'b1 || bus.commit_cnt !== 9'd511) begin
            n_bad++;
            $display("FAIL saturate_check: qed=%0d commit=%0d expected 1/511", bus.qed_ready, bus.commit_cnt);
        end
        step();
    endtask

    task automatic test_random;
        int mode, limit;
        for (int r = 0; r < 10; r++) begin
            clear_tabs();
            mode = $urandom % 3;
            limit = ($urandom % 5 == 0) ? 100 + int'($urandom % 150) : int'($urandom % 20);
            for (int i = 0; i < 300; i++) begin
                s_tab[i] = ($urandom % 4 == 0);
                case (mode)
                    0:       c_tab[i] = 2'($urandom % 4);
                    1:       c_tab[i] = ($urandom % 10 == 0) ? 2'b01 : 2'b00;
                    default: c_tab[i] = ($urandom % 2 == 0) ? 2'b10 : 2'b00;
                endcase
            end
            run_case($sformatf("random%0d", r), limit, 1'($urandom % 2));
        end
    endtask

    task automatic test_reset_mid_dup;
        clear_tabs();
        bus.orig_limit = 8'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (bus.exec_dup !== 1'b1 || bus.ena !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_dup_setup: ena=%0d dup=%0d expected 1/1", bus.ena, bus.exec_dup);
        end
        #3;
        din_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.ena !== 1'b0 || bus.exec_dup !== 1'b0 || bus.busy !== 1'b0 || bus.orig_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: ena=%0d dup=%0d busy=%0d orig=%0d expected 0/0/0/0",
                     bus.ena, bus.exec_dup, bus.busy, bus.orig_cnt);
        end
        #2;
        din_rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clamp();
        test_timeout();
        test_start_busy();
        test_saturate();
        test_random();
        test_reset_mid_dup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
